// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// One pipeline stage register with valid/ready handshaking. It carries an
// opaque payload (in_data) plus a control field (in_ctrl). The control field
// is forced to zero whenever the stage holds no item, so a bubble can never
// trigger a register write, memory write or IO write further down the pipe.
//
// Optional feature (compile-time macro PIPE_SKID_EN):
//   Undefined (default): no skid buffer, and in_ready = !out_valid || out_ready.
//   Defined: adds a one-entry skid register. in_ready then comes straight
//   from a flop, so the upstream ready path has no combinational logic.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control-bit width (zeroed for bubbles)
//   CNT_W   stall counter width
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      drop the stage contents and any item accepted this cycle
//   in_valid   upstream has an item
//   in_ready   stage can accept an item this cycle
//   in_data    upstream payload
//   in_ctrl    upstream control bits
//   out_valid  stage holds an item
//   out_ready  downstream accepts this cycle
//   out_data   registered payload
//   out_ctrl   registered control bits, zero when out_valid=0
//   stall_cnt  saturating count of back-pressured cycles
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic in_fire;
    logic out_fire;
    logic stalled;

    // An item offered during a flush is never taken in.
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready;
    assign stalled  = out_valid && !out_ready && !flush;

    // Back-pressure counter. It stops at all-ones rather than wrapping, and
    // only reset clears it, so a flush does not lose the stall history.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

`ifdef PIPE_SKID_EN

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    // Main register plus skid entry. The skid only fills while the main
    // register is stalled, so an empty main register implies an empty skid.
    // in_ready_q tracks "skid will be empty after this edge"; it is held low
    // during reset so nothing is accepted until the stage is out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            // out_data is left as is; only the valid flag and the control
            // bits have to go away for the item to become a bubble.
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= 1'b1;
            if (out_fire) begin
                if (skid_valid) begin
                    // While the skid is full in_ready is low, so no new
                    // item can compete with the skid entry here.
                    out_data   <= skid_data;
                    out_ctrl   <= skid_ctrl;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    out_data <= in_data;
                    out_ctrl <= in_ctrl;
                end else begin
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                end
            end else if (!out_valid) begin
                if (in_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                    out_ctrl  <= in_ctrl;
                end
            end else if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
                in_ready_q <= 1'b0;
            end else begin
                in_ready_q <= !skid_valid;
            end
        end
    end

`else

    // Without a skid the stage can take a new item whenever the current one
    // is absent or is leaving this cycle.
    assign in_ready = !out_valid || out_ready;

    // Single holding register. A new item replaces a departing one in the
    // same edge, so back-to-back streaming runs without bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg with default parameters. Items
// offered upstream are recorded in a scoreboard queue when the stage takes
// them and compared when they leave downstream. A monitor also checks that
// stalled outputs hold, that bubbles carry zero control bits, and that
// stall_cnt follows an independent saturating count. Directed checks cover
// reset, latency, streaming, saturation, flush, skid/replace and reset
// during a stall. Works with PIPE_SKID_EN defined or undefined.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  ctrl;
    } item_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  stall_cnt;

    int    tests_run;
    int    tests_failed;
    item_t sb_q[$];

    int          exp_stall;
    logic        hold_pending;
    logic [31:0] held_data;
    logic [7:0]  held_ctrl;

    pipe_stage_reg #(
        .DATA_W(32),
        .CTRL_W(8),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then waits until just after the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic [7:0] c, input logic ordy,
                                 input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctrlOf(input logic [31:0] d);
        return d[7:0] ^ 8'h3C;
    endfunction

    // Scoreboard and property monitor, sampled mid-cycle when inputs and
    // registered outputs are both stable.
    initial begin
        exp_stall    = 0;
        hold_pending = 1'b0;
        held_data    = '0;
        held_ctrl    = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_stall    = 0;
            hold_pending = 1'b0;
        end else begin
            checkOutput("stall_cnt_model", 64'(stall_cnt), 64'(exp_stall));
            if (hold_pending) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'(out_data), 64'(held_data));
                checkOutput("hold_ctrl", 64'(out_ctrl), 64'(held_ctrl));
            end
            if (!out_valid) begin
                checkOutput("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    item_t exp_item;
                    exp_item = sb_q.pop_front();
                    checkOutput("sb_data", 64'(out_data), 64'(exp_item.data));
                    checkOutput("sb_ctrl", 64'(out_ctrl), 64'(exp_item.ctrl));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back('{data: in_data, ctrl: in_ctrl});
            end
            hold_pending = out_valid && !out_ready && !flush;
            held_data    = out_data;
            held_ctrl    = out_ctrl;
            if (out_valid && !out_ready && !flush && exp_stall != 255) begin
                exp_stall++;
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_ctrl      = '0;
        out_ready    = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`ifdef PIPE_SKID_EN
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`else
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
`endif
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

        // Single item, latency one.
        applyStimulus(1'b1, 32'h0000_00A5, 8'h81, 1'b1, 1'b0);
        checkOutput("lat1_valid", 64'(out_valid), 64'd1);
        checkOutput("lat1_data", 64'(out_data), 64'h0000_00A5);
        checkOutput("lat1_ctrl", 64'(out_ctrl), 64'h81);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_ctrl", 64'(out_ctrl), 64'd0);

        // Streaming 0..15 with no gaps.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i), ctrlOf(32'(i)), 1'b1, 1'b0);
            checkOutput("stream_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_data", 64'(out_data), 64'(i));
        end
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Long stall: data holds, counter saturates at 255.
        applyStimulus(1'b1, 32'h33, ctrlOf(32'h33), 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        end
        checkOutput("sat_stall_cnt", 64'(stall_cnt), 64'd255);
        checkOutput("sat_out_data", 64'(out_data), 64'h33);
        checkOutput("sat_out_valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Flush while holding 0x11 with 0x22 offered.
        applyStimulus(1'b1, 32'h11, ctrlOf(32'h11), 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, ctrlOf(32'h22), 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("flush_data_held", 64'(out_data), 64'h11);
        checkOutput("flush_keeps_cnt", 64'(stall_cnt), 64'd255);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
            checkOutput("post_flush_empty", 64'(out_valid), 64'd0);
        end

        // Flush in a cycle where 0x11 leaves and 0x22 would be accepted.
        applyStimulus(1'b1, 32'h11, ctrlOf(32'h11), 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, ctrlOf(32'h22), 1'b1, 1'b1);
        checkOutput("flush_xfer_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
            checkOutput("flush_xfer_empty", 64'(out_valid), 64'd0);
        end

        // 0x11 held, 0x22 offered under back-pressure, then release.
        applyStimulus(1'b1, 32'h11, ctrlOf(32'h11), 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, ctrlOf(32'h22), 1'b0, 1'b0);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_data", 64'(out_data), 64'h11);
`ifdef PIPE_SKID_EN
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
`else
        applyStimulus(1'b1, 32'h22, ctrlOf(32'h22), 1'b1, 1'b0);
`endif
        checkOutput("second_valid", 64'(out_valid), 64'd1);
        checkOutput("second_data", 64'(out_data), 64'h22);
        checkOutput("second_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("second_drained", 64'(out_valid), 64'd0);

        // Reset in the middle of a stall with the stage full.
        applyStimulus(1'b1, 32'hAA, ctrlOf(32'hAA), 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBB, ctrlOf(32'hBB), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("midrst_data", 64'(out_data), 64'd0);
        checkOutput("midrst_ctrl", 64'(out_ctrl), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
            checkOutput("midrst_no_item", 64'(out_valid), 64'd0);
        end
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (PC+1, operands, ALU result, etc. packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8, width of control bits (RegWrite, MemWrite, MemToReg, IO_Write, ...) that are forced to zero for bubbles.
REQ-003 Parameter CNT_W, default 8, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard the stage contents and any input accepted this cycle.
REQ-007 in_valid  input  1  upstream holds a valid item.
REQ-008 in_ready  output  1  stage can accept an item this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 out_valid  output  1  stage holds a valid item.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_data  output  DATA_W  registered payload.
REQ-014 out_ctrl  output  CTRL_W  registered control bits; all zero whenever out_valid=0.
REQ-015 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 An item accepted in cycle N with the stage empty and no flush SHALL appear on out_valid/out_data/out_ctrl in cycle N+1 (latency 1).
REQ-018 When out_valid=1 and out_ready=0, out_data and out_ctrl SHALL hold unchanged.
REQ-019 Items SHALL leave in acceptance order with no loss and no duplication; maximum occupancy is 1 (2 with the skid buffer).
REQ-020 Simultaneous output and input transfer in one cycle SHALL replace the held item with the new one, out_valid remaining 1.
REQ-021 flush=1 SHALL, at the next edge, clear out_valid and skid occupancy, zero out_ctrl, hold out_data, and drop any item accepted in the flush cycle.
REQ-022 flush SHALL override simultaneous input acceptance and output hold; an output transfer in the flush cycle still completes downstream.
REQ-023 stall_cnt SHALL increment each cycle with out_valid=1, out_ready=0, flush=0 and saturate at 2^CNT_W-1 without wrapping.
REQ-024 stall_cnt SHALL be cleared only by reset, not by flush.

Reset
REQ-025 With rst=1 at a rising edge: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, skid empty.
REQ-026 rst SHALL take priority over flush and all transfers; a reset mid-stall discards held and skid items.
REQ-027 in_ready during reset SHALL be 0 with the skid buffer and follow REQ-029 without it.

Configuration
REQ-028 Macro PIPE_SKID_EN defined: a one-entry skid register is included; in_ready SHALL be a registered signal equal to "skid empty"; an item arriving while out_valid=1 and out_ready=0 is captured in the skid, in_ready drops the next cycle, and the skid item moves to the main register on the next output transfer, raising in_ready the cycle after.
REQ-029 Macro PIPE_SKID_EN undefined: no skid; in_ready = !out_valid || out_ready, combinational.

Verification
REQ-030 Reset, then in_valid=1, in_data=0x0000_00A5, in_ctrl=0x81, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ctrl=0x81.
REQ-031 Streaming 16 items 0..15 with out_ready=1 every cycle -> 16 consecutive outputs 0..15, one per cycle, no gaps after the first.
REQ-032 Hold out_ready=0 for 300 cycles with out_valid=1 (CNT_W=8) -> out_data stable, stall_cnt reaches 255 and stays 255.
REQ-033 Item 0x11 held, flush=1 with in_valid=1 in_data=0x22 -> next cycle out_valid=0, out_ctrl=0, 0x22 never appears at output.
REQ-034 PIPE_SKID_EN defined: 0x11 held, out_ready=0, send 0x22 -> in_ready=0 next cycle; then out_ready=1 -> outputs 0x11 then 0x22 in consecutive cycles, in_ready=1 after.
REQ-035 rst=1 asserted during a 5-cycle stall with skid full -> out_valid=0, stall_cnt=0, no held item emerges after reset release.
